// File: rtl/lsu_split.sv
// lsu_split: load/store unit between the memory-access stage and a
// byte-strobed single-port data RAM with one-cycle read latency.
// Handles one request at a time. A request whose bytes span two words is
// split into two word accesses, and the loaded bytes are reassembled and
// sign- or zero-extended.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_addr           byte address
//   req_we             1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       zero-extend load data
//   req_wdata          right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores/errors)
//   resp_err           illegal size flag, valid with resp_valid
//   mem_addr           word address to RAM
//   mem_re             read strobe, data returns on mem_rdata next cycle
//   mem_wstrb          per-byte write enables
//   mem_wdata          lane-positioned write data
//   mem_rdata          read data from RAM
module lsu_split #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-3:0] mem_addr,
    output logic                 mem_re,
    output logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);
    localparam int WA = ADDR_BITS - 2;

    typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT, S_RESP} state_t;

    // Byte-enable mask across two consecutive words.
    function automatic logic [7:0] mask8_f(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Store data moved into byte lanes across two words. Bits above the
    // access size are cleared so lanes outside the strobe carry zeros.
    function automatic logic [63:0] lanes_f(input logic [1:0] size, input logic [1:0] off,
                                            input logic [31:0] wdata);
        logic [31:0] sized;
        case (size)
            2'b00:   sized = {24'b0, wdata[7:0]};
            2'b01:   sized = {16'b0, wdata[15:0]};
            default: sized = wdata;
        endcase
        return {32'b0, sized} << {off, 3'b000};
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           word0_q, word0_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [WA-1:0]         mem_addr_q, mem_addr_d;
    logic                  mem_re_q, mem_re_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    // Values derived from the incoming request (used on acceptance).
    logic [7:0]            in_mask;
    logic [63:0]           in_lanes;
    // Values derived from the latched request.
    logic [7:0]            cur_mask;
    logic [63:0]           cur_lanes;
    logic                  cur_cross;
    logic [WA-1:0]         cur_wa1;
    logic [31:0]           ld_lo, ld_hi;
    logic [63:0]           ld_shift;
    logic [31:0]           ld_data;

    assign in_mask   = mask8_f(req_size, req_addr[1:0]);
    assign in_lanes  = lanes_f(req_size, req_addr[1:0], req_wdata);
    assign cur_mask  = mask8_f(size_q, addr_q[1:0]);
    assign cur_lanes = lanes_f(size_q, addr_q[1:0], wdata_q);
    assign cur_cross = |cur_mask[7:4];
    // Natural WA-bit wrap takes the top word back to word 0.
    assign cur_wa1   = addr_q[ADDR_BITS-1:2] + {{(WA-1){1'b0}}, 1'b1};

    // In WAIT, mem_rdata holds the last word read; word 0 was latched
    // earlier only when the access crossed.
    always_comb begin
        ld_lo    = cur_cross ? word0_q : mem_rdata;
        ld_hi    = cur_cross ? mem_rdata : 32'b0;
        ld_shift = {ld_hi, ld_lo} >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   ld_data = uns_q ? {24'b0, ld_shift[7:0]}
                                     : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_data = uns_q ? {16'b0, ld_shift[15:0]}
                                     : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift[31:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        word0_d      = word0_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = 1'b0;
        mem_wstrb_d  = 4'b0;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (req_size == 2'b11) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'b0;
                    end else begin
                        state_d    = S_ACC0;
                        mem_addr_d = req_addr[ADDR_BITS-1:2];
                        mem_re_d   = ~req_we;
                        if (req_we) begin
                            mem_wstrb_d = in_mask[3:0];
                            mem_wdata_d = in_lanes[31:0];
                        end
                    end
                end
            end
            S_ACC0: begin
                if (cur_cross) begin
                    state_d    = S_ACC1;
                    mem_addr_d = cur_wa1;
                    mem_re_d   = ~we_q;
                    if (we_q) begin
                        mem_wstrb_d = cur_mask[7:4];
                        mem_wdata_d = cur_lanes[63:32];
                    end
                end else if (we_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACC1: begin
                // Word 0 of a crossing load arrives during this cycle.
                word0_d = mem_rdata;
                if (we_q) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'b0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_data;
                resp_err_d   = 1'b0;
            end
            S_RESP: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_rdata_d = 32'b0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b0;
            uns_q        <= 1'b0;
            wdata_q      <= 32'b0;
            word0_q      <= 32'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0;
            mem_wdata_q  <= 32'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            word0_q      <= word0_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_split.sv
// Testbench for lsu_split: a behavioural RAM plus a byte-level model of
// each access that predicts the word accesses, strobes, latency and the
// extended load result.
module tb_lsu_split;
    localparam int AB = 14;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AB-1:0] req_addr = '0;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = 32'b0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AB-3:0] mem_addr;
    logic          mem_re;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_split #(.ADDR_BITS(AB)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM: one-cycle read latency, byte-strobed writes, preload port.
    logic [31:0] ram [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = 32'b0;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        if (mem_re) mem_rdata <= ram[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle. Model: walk the accessed bytes
    // in order, grouping them into the words they land in.
    task automatic do_req(input string nm, input logic [13:0] a, input logic we,
                          input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                          input logic [31:0] lit);
        int n, nacc, lat;
        logic [11:0] wa [2];
        logic [3:0]  st [2];
        logic [31:0] wdx [2];
        logic [31:0] expw [2];
        logic [31:0] val;
        logic [13:0] ba;
        logic [11:0] w;
        logic [1:0]  ln;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        nacc = 0;
        val = 32'b0;
        for (int k = 0; k < 2; k++) begin
            wa[k] = '0; st[k] = '0; wdx[k] = '0; expw[k] = '0;
        end
        if (sz != 2'd3) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 14'(i);
                w  = ba[13:2];
                ln = ba[1:0];
                if (nacc == 0 || wa[nacc-1] != w) begin
                    wa[nacc]   = w;
                    expw[nacc] = ram[w];
                    nacc++;
                end
                st[nacc-1][ln]          = 1'b1;
                wdx[nacc-1][8*ln +: 8]  = wd[8*i +: 8];
                expw[nacc-1][8*ln +: 8] = wd[8*i +: 8];
                val[8*i +: 8]           = ram[w][8*ln +: 8];
            end
        end
        if (!uns && sz == 2'd0 && val[7])  val[31:8]  = '1;
        if (!uns && sz == 2'd1 && val[15]) val[31:16] = '1;
        if (we || sz == 2'd3) val = 32'b0;
        lat = (sz == 2'd3) ? 1 : (we ? nacc + 1 : nacc + 2);

        req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        chk({nm, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k <= nacc) begin
                chk($sformatf("%s c%0d re", nm, k), 32'(mem_re), 32'(!we));
                chk($sformatf("%s c%0d wstrb", nm, k), 32'(mem_wstrb), we ? 32'(st[k-1]) : 32'd0);
                chk($sformatf("%s c%0d addr", nm, k), 32'(mem_addr), 32'(wa[k-1]));
                if (we) chk($sformatf("%s c%0d wdata", nm, k), mem_wdata, wdx[k-1]);
            end else begin
                chk($sformatf("%s c%0d re", nm, k), 32'(mem_re), 32'd0);
                chk($sformatf("%s c%0d wstrb", nm, k), 32'(mem_wstrb), 32'd0);
            end
            chk($sformatf("%s c%0d valid", nm, k), 32'(resp_valid), 32'(k == lat));
            if (k == lat) begin
                chk({nm, " rdata"}, resp_rdata, val);
                chk({nm, " rdata literal"}, resp_rdata, lit);
                chk({nm, " err"}, 32'(resp_err), 32'(sz == 2'd3));
            end
            @(negedge clk);
        end
        chk({nm, " valid after"}, 32'(resp_valid), 32'd0);
        chk({nm, " ready after"}, 32'(req_ready), 32'd1);
        if (we)
            for (int k = 0; k < nacc; k++)
                chk($sformatf("%s ram[%h]", nm, wa[k]), ram[wa[k]], expw[k]);
        $display("[TB] txn %s addr=%h we=%0d size=%0d rdata=%h err=%0d accesses=%0d",
                 nm, a, we, sz, resp_rdata, resp_err, nacc);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({nm, " resp_rdata"}, resp_rdata, 32'd0);
        chk({nm, " resp_err"}, 32'(resp_err), 32'd0);
        chk({nm, " mem_re"}, 32'(mem_re), 32'd0);
        chk({nm, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        poke(12'h004, 32'hDEADBEEF);
        do_req("LW aligned", 14'h0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);

        poke(12'h004, 32'h44332211);
        poke(12'h005, 32'h88776655);
        do_req("LW cross", 14'h0013, 1'b0, 2'b10, 1'b0, 32'h0, 32'h77665544);
        do_req("LB signed", 14'h0017, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFF88);
        do_req("LHU aligned", 14'h0012, 1'b0, 2'b01, 1'b1, 32'h0, 32'h00004433);

        poke(12'h000, 32'h80000000);
        poke(12'h001, 32'h000000FF);
        do_req("LH cross", 14'h0003, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFFFF80);
        do_req("LHU cross", 14'h0003, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000FF80);

        poke(12'h001, 32'h0);
        poke(12'h002, 32'h0);
        do_req("SW cross", 14'h0006, 1'b1, 2'b10, 1'b0, 32'hAABBCCDD, 32'h0);
        chk("SW ram1 literal", ram[1], 32'hCCDD0000);
        chk("SW ram2 literal", ram[2], 32'h0000AABB);
        do_req("LW readback", 14'h0006, 1'b0, 2'b10, 1'b0, 32'h0, 32'hAABBCCDD);
        do_req("SB", 14'h0005, 1'b1, 2'b00, 1'b0, 32'h00001234, 32'h0);
        chk("SB ram1 literal", ram[1], 32'hCCDD3400);

        poke(12'hFFF, 32'h99887766);
        poke(12'h000, 32'h44332211);
        do_req("LW wrap", 14'h3FFE, 1'b0, 2'b10, 1'b0, 32'h0, 32'h22119988);
        do_req("SH wrap", 14'h3FFF, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, 32'h0);
        chk("SH wrap ram0 literal", ram[0], 32'h443322BE);
        do_req("illegal", 14'h0010, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

        // Reset asserted during the second access of a crossing load.
        poke(12'h004, 32'h44332211);
        req_addr = 14'h0013; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst ACC1 addr", 32'(mem_addr), 32'h005);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst inflight");
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rst quiet%0d valid", k), 32'(resp_valid), 32'd0);
            chk($sformatf("rst quiet%0d re", k), 32'(mem_re), 32'd0);
        end
        $display("[TB] txn reset-abort addr=0013 no response");
        do_req("LW after reset", 14'h0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'h44332211);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_split.md
Name: lsu_split

Overview:
- Load/store unit between the core's memory-access stage and a byte-strobed single-port data RAM.
- Accepts one byte/half/word request at a time and splits word-boundary-crossing accesses into two word accesses.
- Assembles and sign/zero-extends load data; generates per-byte strobes for stores.
- Exists so misaligned loads and stores that cross a word boundary execute correctly instead of being truncated.

Parameters:
- ADDR_BITS, 14, byte address width; the word address is ADDR_BITS-2 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_addr  in  ADDR_BITS  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  high with resp_valid for an illegal size
- mem_addr  out  ADDR_BITS-2  word address
- mem_re  out  1  read strobe; RAM returns mem_rdata the following cycle
- mem_wstrb  out  4  byte write enables; nonzero means write
- mem_wdata  out  32  write data, lane-positioned
- mem_rdata  in  32  read data

Behaviour:
- Handshake:
  - Transfer occurs on a clock edge where req_valid && req_ready.
  - The request is latched; req_ready drops on the next cycle.
  - One request is outstanding at a time.
- Derived values:
  - off = addr[1:0]; wa0 = addr[ADDR_BITS-1:2]; wa1 = wa0 + 1, wrapping modulo 2^(ADDR_BITS-2).
  - mask8 = (byte 0x1, half 0x3, word 0xF) << off.
  - cross = mask8[7:4] != 0, i.e. half with off=3, or word with off!=0.
- States: IDLE, ACC0, ACC1, WAIT, RESP. All outputs are registered.
- Edge naming: the acceptance edge is E0; cycle n is the cycle following edge En-1.
- IDLE (req_ready=1): on acceptance:
  - size 11 -> RESP with resp_err=1; no memory access.
  - otherwise -> ACC0.
- ACC0 (cycle 1):
  - mem_addr=wa0.
  - Load: mem_re=1.
  - Store: mem_wstrb=mask8[3:0], mem_wdata=low 32 bits of ({32'b0,wdata} << 8*off).
  - Next state: cross ? ACC1 : (load ? WAIT : RESP).
- ACC1 (cycle 2):
  - mem_addr=wa1; load mem_re=1, or store mem_wstrb=mask8[7:4] with the upper 32 bits of the shifted data.
  - A load latches the word-0 data (mem_rdata) at the end of this cycle.
  - Next state: load ? WAIT : RESP.
- WAIT: latches the last returned word; lo = word0, hi = word1 if cross else 0.
  - rdata = ({hi,lo} >> 8*off) truncated to size, then sign-extended (req_unsigned=0) or zero-extended.
  - Registered into resp_rdata; next state RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Outside its issuing state, mem_re=0 and mem_wstrb=0.
- Latency from E0 to resp_valid:
  - aligned load 3 cycles, crossing load 4.
  - aligned store 2, crossing store 3.
  - illegal size 1.
- Reset (resetn=0 at an edge):
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_re=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - Reset has priority over any in-flight request: the request is abandoned with no further memory access and no response.
  - A store half already written stays written.
- A request presented while req_ready=0 is ignored; the requester must hold it.
- Wrap: a crossing access at the top word continues at word 0.

Test Plan:
- Aligned LW, addr 0x0010, word4=0xDEADBEEF -> one mem_re cycle at wa 0x004; resp_valid in cycle 3; rdata 0xDEADBEEF, err 0.
- Crossing LW, addr 0x0013, word4=0x44332211, word5=0x88776655 -> mem_re at wa 0x004 then 0x005; resp_valid in cycle 4; rdata 0x77665544.
- Crossing LH, addr 0x0003, word0=0x80000000, word1=0x000000FF -> signed rdata 0xFFFFFF80; with req_unsigned=1 -> 0x0000FF80.
- Crossing SW, addr 0x0006, data 0xAABBCCDD:
  - cycle 1: wa 1, wstrb 1100, wdata 0xCCDD0000.
  - cycle 2: wa 2, wstrb 0011, wdata 0x0000AABB.
  - resp_valid in cycle 3.
- Wrap: LW at 0x3FFE -> reads wa 0xFFF then 0x000. SB at 0x0005 data 0x1234 -> wstrb 0010, wdata 0x00003400, single access.
- Illegal size 11 -> resp_valid in cycle 1 with err=1, no mem access. Reset asserted in ACC1 of a crossing load -> next cycle all outputs at reset values, req_ready=1, no resp_valid.
